blob_centroid_tracker: RTL and testbench

BLOB_CENTROID_TRACKER -- requirements
Module: blob_centroid_tracker

---
 rtl/blob_pkg.sv | 17 +
 rtl/seq_divider.sv | 66 ++++++
 rtl/blob_centroid_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_blob_centroid_tracker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared types and sizing for the blob centroid tracker: FSM state encoding,
// default accumulator widths and the pixel coordinate width.
package blob_pkg;

    localparam int COORD_W   = 10;
    localparam int SUM_W_DEF = 28;
    localparam int CNT_W_DEF = 18;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV_X,
        DIV_Y,
        PUBLISH
    } blob_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done is high during
// the final iteration and quotient shows the finished result in that cycle.
module seq_divider #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 18,
    parameter int OUT_W      = 10
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      quotient
);

    localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_reg, quo_next;
    logic [DIVISOR_W-1:0]  rem_reg, rem_next, den_reg;
    logic [DIVISOR_W:0]    trial;
    logic [CNT_BITS-1:0]   cnt_reg;
    logic                  busy_reg;

    // The remainder stays below the divisor, so the low bits of the difference are exact.
    always_comb begin
        trial = {rem_reg, quo_reg[DIVIDEND_W-1]};
        if (trial >= {1'b0, den_reg}) begin
            rem_next = trial[DIVISOR_W-1:0] - den_reg;
            quo_next = {quo_reg[DIVIDEND_W-2:0], 1'b1};
        end else begin
            rem_next = trial[DIVISOR_W-1:0];
            quo_next = {quo_reg[DIVIDEND_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (srst || abort) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
            den_reg  <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= CNT_BITS'(DIVIDEND_W);
            quo_reg  <= dividend;
            rem_reg  <= '0;
            den_reg  <= divisor;
        end else if (busy_reg) begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg - CNT_BITS'(1);
            if (cnt_reg == CNT_BITS'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = busy_reg && (cnt_reg == CNT_BITS'(1));
    assign quotient = quo_next[OUT_W-1:0];

endmodule

// File: rtl/blob_centroid_tracker.sv
// Accumulates dark-pixel coordinates over a window and divides by the count to
// publish a centroid. Optional bounding box outputs are enabled by BLOB_BBOX_EN.
module blob_centroid_tracker
    import blob_pkg::*;
#(
    parameter int SUM_W      = SUM_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MIN_PIXELS = 16
) (
    input  logic               Clk,
    input  logic               RST,
    input  logic               RstH,
    input  logic               Get,
    input  logic               Get_done,
    input  logic               x_values,
    input  logic [COORD_W-1:0] Draw_X,
    input  logic [COORD_W-1:0] Draw_Y,
    output logic [COORD_W-1:0] Centroid_X,
    output logic [COORD_W-1:0] Centroid_Y,
    output logic [CNT_W-1:0]   Pixel_Count,
    output logic               Found,
    output logic               Valid,
    output logic               Busy
`ifdef BLOB_BBOX_EN
    ,
    output logic [COORD_W-1:0] Bbox_Xmin,
    output logic [COORD_W-1:0] Bbox_Xmax,
    output logic [COORD_W-1:0] Bbox_Ymin,
    output logic [COORD_W-1:0] Bbox_Ymax
`endif
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    blob_state_t state_reg, state_next;

    logic [CNT_W-1:0]   count_reg, count_next;
    logic [SUM_W-1:0]   sum_x_reg, sum_x_next, sum_y_reg, sum_y_next;
    logic [SUM_W:0]     sum_x_wide, sum_y_wide;
    logic               take, frame_done, enough, publish_skip, publish_div;

    logic [COORD_W-1:0] centroid_x_reg, centroid_y_reg, cx_pend_reg;
    logic [CNT_W-1:0]   pix_count_reg;
    logic               found_reg;

    logic               div_start, div_busy, div_done;
    logic [SUM_W-1:0]   div_dividend;
    logic [CNT_W-1:0]   div_divisor;
    logic [COORD_W-1:0] div_quotient;

    assign take         = (state_reg == ACCUM) && Get && !x_values;
    assign frame_done   = (state_reg == ACCUM) && Get_done && !RstH;
    assign enough       = (count_next >= MIN_CNT);
    assign publish_skip = frame_done && !enough;
    assign publish_div  = (state_reg == DIV_Y) && div_done && !RstH;

    // Saturating accumulation; the next-values also feed the frame-end decision
    // so a sample arriving with Get_done is counted.
    always_comb begin
        count_next = count_reg;
        sum_x_next = sum_x_reg;
        sum_y_next = sum_y_reg;
        sum_x_wide = {1'b0, sum_x_reg} + (SUM_W+1)'(Draw_X);
        sum_y_wide = {1'b0, sum_y_reg} + (SUM_W+1)'(Draw_Y);
        if (take) begin
            count_next = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
            sum_x_next = sum_x_wide[SUM_W] ? '1 : sum_x_wide[SUM_W-1:0];
            sum_y_next = sum_y_wide[SUM_W] ? '1 : sum_y_wide[SUM_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (RST || RstH) begin
            count_reg <= '0;
            sum_x_reg <= '0;
            sum_y_reg <= '0;
        end else begin
            count_reg <= count_next;
            sum_x_reg <= sum_x_next;
            sum_y_reg <= sum_y_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (RstH) state_next = ACCUM;
            ACCUM:   if (!RstH && Get_done) state_next = enough ? DIV_X : PUBLISH;
            DIV_X:   if (RstH) state_next = ACCUM;
                     else if (div_done) state_next = DIV_Y;
            DIV_Y:   if (RstH) state_next = ACCUM;
                     else if (div_done) state_next = PUBLISH;
            PUBLISH: state_next = RstH ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // X division launches straight from the frame end; Y launches on the first
    // DIV_Y cycle, once the divider has gone idle after X.
    always_comb begin
        Valid        = (state_reg == PUBLISH);
        Busy         = (state_reg == DIV_X) || (state_reg == DIV_Y);
        div_start    = (frame_done && enough) ||
                       ((state_reg == DIV_Y) && !div_busy && !RstH);
        div_dividend = (state_reg == DIV_Y) ? sum_y_reg : sum_x_next;
        div_divisor  = (state_reg == DIV_Y) ? count_reg : count_next;
    end

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .OUT_W      (COORD_W)
    ) u_div (
        .clk      (Clk),
        .srst     (RST),
        .start    (div_start),
        .abort    (RstH),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge Clk) begin
        if (RST) begin
            pix_count_reg  <= '0;
            found_reg      <= 1'b0;
            cx_pend_reg    <= '0;
            centroid_x_reg <= '0;
            centroid_y_reg <= '0;
        end else begin
            if (frame_done) pix_count_reg <= count_next;
            if (publish_skip) found_reg <= 1'b0;
            if ((state_reg == DIV_X) && div_done && !RstH) cx_pend_reg <= div_quotient;
            if (publish_div) begin
                centroid_x_reg <= cx_pend_reg;
                centroid_y_reg <= div_quotient;
                found_reg      <= 1'b1;
            end
        end
    end

    assign Centroid_X  = centroid_x_reg;
    assign Centroid_Y  = centroid_y_reg;
    assign Pixel_Count = pix_count_reg;
    assign Found       = found_reg;

`ifdef BLOB_BBOX_EN
    // Index 0 tracks X, index 1 tracks Y.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bbox
        logic [COORD_W-1:0] coord;
        logic [COORD_W-1:0] bmin_reg, bmax_reg, bmin_next, bmax_next;
        logic [COORD_W-1:0] pmin_reg, pmax_reg;

        assign coord = (gi == 0) ? Draw_X : Draw_Y;

        always_comb begin
            bmin_next = bmin_reg;
            bmax_next = bmax_reg;
            if (take) begin
                if (coord < bmin_reg) bmin_next = coord;
                if (coord > bmax_reg) bmax_next = coord;
            end
        end

        always_ff @(posedge Clk) begin
            if (RST) begin
                bmin_reg <= '0;
                bmax_reg <= '0;
                pmin_reg <= '0;
                pmax_reg <= '0;
            end else begin
                if (RstH) begin
                    bmin_reg <= '1;
                    bmax_reg <= '0;
                end else begin
                    bmin_reg <= bmin_next;
                    bmax_reg <= bmax_next;
                end
                if (publish_skip || publish_div) begin
                    pmin_reg <= bmin_next;
                    pmax_reg <= bmax_next;
                end
            end
        end
    end

    assign Bbox_Xmin = g_bbox[0].pmin_reg;
    assign Bbox_Xmax = g_bbox[0].pmax_reg;
    assign Bbox_Ymin = g_bbox[1].pmin_reg;
    assign Bbox_Ymax = g_bbox[1].pmax_reg;
`endif

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Directed bench: two tracker instances (MIN_PIXELS=2 and 16) share stimulus;
// each scenario task checks its hand-computed results inline.
module tb_blob_centroid_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1, rsth = 1'b0, get = 1'b0, get_done = 1'b0, xv = 1'b1;
    logic [9:0] dx = '0, dy = '0;

    logic [9:0]  o2_cx, o2_cy, o16_cx, o16_cy;
    logic [17:0] o2_pc, o16_pc;
    logic        o2_found, o2_valid, o2_busy, o16_found, o16_valid, o16_busy;
`ifdef BLOB_BBOX_EN
    logic [9:0]  o2_xmin, o2_xmax, o2_ymin, o2_ymax;
    logic [9:0]  o16_xmin, o16_xmax, o16_ymin, o16_ymax;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    blob_centroid_tracker #(.SUM_W(28), .CNT_W(18), .MIN_PIXELS(2)) u_dut2 (
        .Clk(clk), .RST(rst), .RstH(rsth), .Get(get), .Get_done(get_done),
        .x_values(xv), .Draw_X(dx), .Draw_Y(dy),
        .Centroid_X(o2_cx), .Centroid_Y(o2_cy), .Pixel_Count(o2_pc),
        .Found(o2_found), .Valid(o2_valid), .Busy(o2_busy)
`ifdef BLOB_BBOX_EN
        , .Bbox_Xmin(o2_xmin), .Bbox_Xmax(o2_xmax), .Bbox_Ymin(o2_ymin), .Bbox_Ymax(o2_ymax)
`endif
    );

    blob_centroid_tracker #(.SUM_W(28), .CNT_W(18), .MIN_PIXELS(16)) u_dut16 (
        .Clk(clk), .RST(rst), .RstH(rsth), .Get(get), .Get_done(get_done),
        .x_values(xv), .Draw_X(dx), .Draw_Y(dy),
        .Centroid_X(o16_cx), .Centroid_Y(o16_cy), .Pixel_Count(o16_pc),
        .Found(o16_found), .Valid(o16_valid), .Busy(o16_busy)
`ifdef BLOB_BBOX_EN
        , .Bbox_Xmin(o16_xmin), .Bbox_Xmax(o16_xmax), .Bbox_Ymin(o16_ymin), .Bbox_Ymax(o16_ymax)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rsth();
        rsth = 1'b1;
        step();
        rsth = 1'b0;
    endtask

    task automatic sample(input int x, input int y, input bit dark);
        get = 1'b1; xv = !dark; dx = 10'(x); dy = 10'(y);
        step();
        get = 1'b0; xv = 1'b1;
    endtask

    // Issue Get_done (plus any sample the caller left on the bus) and watch
    // Valid for 70 cycles; n=1 is the cycle right after Get_done.
    task automatic end_frame(input bit inject, output int first2, output int first16,
                             output int pulses2, output int pulses16,
                             output logic busy2_n1, output logic busy2_at_valid);
        get_done = 1'b1;
        step();
        get_done = 1'b0; get = 1'b0; xv = 1'b1;
        first2 = 0; first16 = 0; pulses2 = 0; pulses16 = 0;
        busy2_n1 = o2_busy; busy2_at_valid = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            if (o2_valid) begin
                pulses2++;
                if (first2 == 0) begin first2 = n; busy2_at_valid = o2_busy; end
            end
            if (o16_valid) begin
                pulses16++;
                if (first16 == 0) first16 = n;
            end
            if (inject && n >= 5 && n <= 8) begin
                get = 1'b1; xv = 1'b0; dx = 10'd1000; dy = 10'd1000; get_done = 1'b1;
            end else begin
                get = 1'b0; xv = 1'b1; get_done = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++; if (o2_cx !== 10'd0 || o2_cy !== 10'd0) begin bad++; $display("FAIL reset_centroid got=%0d,%0d exp=0,0", o2_cx, o2_cy); end
        total++; if (o2_pc !== 18'd0 || o16_pc !== 18'd0) begin bad++; $display("FAIL reset_count got=%0d,%0d exp=0,0", o2_pc, o16_pc); end
        total++; if ({o2_found, o2_valid, o2_busy, o16_found, o16_valid, o16_busy} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {o2_found, o2_valid, o2_busy, o16_found, o16_valid, o16_busy}); end
        rst = 1'b0;
        step();
        total++; if (o2_busy !== 1'b0 || o2_valid !== 1'b0) begin bad++; $display("FAIL reset_idle got busy=%b valid=%b exp=0,0", o2_busy, o2_valid); end
        $display("test_reset: done");
    endtask

    task automatic test_main();
        int f2, f16, p2, p16; logic b1, bv;
        pulse_rsth();
        sample(300, 200, 1'b1);
        sample(302, 200, 1'b1);
        sample(304, 202, 1'b1);
        end_frame(1'b0, f2, f16, p2, p16, b1, bv);
        total++; if (f2 != 58) begin bad++; $display("FAIL main_latency got=%0d exp=58", f2); end
        total++; if (p2 != 1) begin bad++; $display("FAIL main_pulses got=%0d exp=1", p2); end
        total++; if (b1 !== 1'b1 || bv !== 1'b0) begin bad++; $display("FAIL main_busy got n1=%b valid=%b exp=1,0", b1, bv); end
        total++; if (o2_cx !== 10'd302 || o2_cy !== 10'd200) begin bad++; $display("FAIL main_centroid got=%0d,%0d exp=302,200", o2_cx, o2_cy); end
        total++; if (o2_pc !== 18'd3 || o2_found !== 1'b1) begin bad++; $display("FAIL main_count got pc=%0d found=%b exp=3,1", o2_pc, o2_found); end
        total++; if (f16 != 1 || o16_found !== 1'b0 || o16_pc !== 18'd3) begin bad++; $display("FAIL main_min16 got lat=%0d found=%b pc=%0d exp=1,0,3", f16, o16_found, o16_pc); end
        total++; if (o16_cx !== 10'd0 || o16_cy !== 10'd0) begin bad++; $display("FAIL main_min16_hold got=%0d,%0d exp=0,0", o16_cx, o16_cy); end
`ifdef BLOB_BBOX_EN
        total++; if (o2_xmin !== 10'd300 || o2_xmax !== 10'd304) begin bad++; $display("FAIL bbox_x got=%0d..%0d exp=300..304", o2_xmin, o2_xmax); end
        total++; if (o2_ymin !== 10'd200 || o2_ymax !== 10'd202) begin bad++; $display("FAIL bbox_y got=%0d..%0d exp=200..202", o2_ymin, o2_ymax); end
`endif
        $display("test_main: centroid=%0d,%0d latency=%0d", o2_cx, o2_cy, f2);
    endtask

    task automatic test_same_cycle();
        int f2, f16, p2, p16; logic b1, bv;
        pulse_rsth();
        sample(100, 50, 1'b1);
        get = 1'b1; xv = 1'b0; dx = 10'd200; dy = 10'd150;
        end_frame(1'b0, f2, f16, p2, p16, b1, bv);
        total++; if (f2 != 58 || o2_pc !== 18'd2) begin bad++; $display("FAIL same_cycle_count got lat=%0d pc=%0d exp=58,2", f2, o2_pc); end
        total++; if (o2_cx !== 10'd150 || o2_cy !== 10'd100) begin bad++; $display("FAIL same_cycle_centroid got=%0d,%0d exp=150,100", o2_cx, o2_cy); end
        $display("test_same_cycle: centroid=%0d,%0d", o2_cx, o2_cy);
    endtask

    task automatic test_too_few();
        int f2, f16, p2, p16; logic b1, bv;
        pulse_rsth();
        sample(10, 20, 1'b1);
        end_frame(1'b0, f2, f16, p2, p16, b1, bv);
        total++; if (f16 != 1 || p16 != 1 || o16_found !== 1'b0 || o16_pc !== 18'd1) begin bad++; $display("FAIL few_min16 got lat=%0d pulses=%0d found=%b pc=%0d exp=1,1,0,1", f16, p16, o16_found, o16_pc); end
        total++; if (f2 != 1 || o2_found !== 1'b0) begin bad++; $display("FAIL few_min2 got lat=%0d found=%b exp=1,0", f2, o2_found); end
        total++; if (o2_cx !== 10'd150 || o2_cy !== 10'd100) begin bad++; $display("FAIL few_hold got=%0d,%0d exp=150,100", o2_cx, o2_cy); end
        $display("test_too_few: pixel_count=%0d", o16_pc);
    endtask

    task automatic test_light_only();
        int f2, f16, p2, p16; logic b1, bv;
        pulse_rsth();
        for (int i = 0; i < 100; i++) sample(i, i + 5, 1'b0);
        end_frame(1'b0, f2, f16, p2, p16, b1, bv);
        total++; if (o2_pc !== 18'd0 || o16_pc !== 18'd0) begin bad++; $display("FAIL light_count got=%0d,%0d exp=0,0", o2_pc, o16_pc); end
        total++; if (f2 != 1 || o2_found !== 1'b0) begin bad++; $display("FAIL light_found got lat=%0d found=%b exp=1,0", f2, o2_found); end
        $display("test_light_only: pixel_count=%0d", o2_pc);
    endtask

    task automatic test_ignore_outside();
        int f2, f16, p2, p16; logic b1, bv;
        pulse_rsth();
        sample(40, 60, 1'b1);
        sample(42, 62, 1'b1);
        end_frame(1'b1, f2, f16, p2, p16, b1, bv);
        total++; if (f2 != 58 || p2 != 1) begin bad++; $display("FAIL outside_valid got lat=%0d pulses=%0d exp=58,1", f2, p2); end
        total++; if (o2_cx !== 10'd41 || o2_cy !== 10'd61 || o2_pc !== 18'd2) begin bad++; $display("FAIL outside_result got=%0d,%0d pc=%0d exp=41,61,2", o2_cx, o2_cy, o2_pc); end
        total++; if (p16 != 1 || o16_pc !== 18'd2) begin bad++; $display("FAIL outside_idle got pulses=%0d pc=%0d exp=1,2", p16, o16_pc); end
        $display("test_ignore_outside: centroid=%0d,%0d", o2_cx, o2_cy);
    endtask

    task automatic test_abort();
        int f2, f16, p2, p16, v2; logic b1, bv;
        pulse_rsth();
        sample(10, 10, 1'b1);
        sample(20, 30, 1'b1);
        sample(30, 50, 1'b1);
        get_done = 1'b1;
        step();
        get_done = 1'b0;
        repeat (9) step();
        total++; if (o2_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", o2_busy); end
        rsth = 1'b1;
        step();
        rsth = 1'b0;
        total++; if (o2_busy !== 1'b0 || o2_valid !== 1'b0) begin bad++; $display("FAIL abort_busy_after got busy=%b valid=%b exp=0,0", o2_busy, o2_valid); end
        v2 = 0;
        for (int n = 0; n < 80; n++) begin
            if (o2_valid) v2++;
            step();
        end
        total++; if (v2 != 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", v2); end
        total++; if (o2_cx !== 10'd41 || o2_cy !== 10'd61 || o2_pc !== 18'd3) begin bad++; $display("FAIL abort_hold got=%0d,%0d pc=%0d exp=41,61,3", o2_cx, o2_cy, o2_pc); end
        end_frame(1'b0, f2, f16, p2, p16, b1, bv);
        total++; if (f2 != 1 || o2_pc !== 18'd0 || o2_found !== 1'b0) begin bad++; $display("FAIL abort_resume got lat=%0d pc=%0d found=%b exp=1,0,0", f2, o2_pc, o2_found); end
        $display("test_abort: resumed pixel_count=%0d", o2_pc);
    endtask

    task automatic test_rst_mid_div();
        int v2;
        pulse_rsth();
        sample(300, 200, 1'b1);
        sample(302, 200, 1'b1);
        sample(304, 202, 1'b1);
        get_done = 1'b1;
        step();
        get_done = 1'b0;
        repeat (39) step();
        total++; if (o2_busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%b exp=1", o2_busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (o2_cx !== 10'd0 || o2_cy !== 10'd0 || o2_pc !== 18'd0 || o16_pc !== 18'd0) begin bad++; $display("FAIL rst_outputs got=%0d,%0d pc=%0d,%0d exp=0,0,0,0", o2_cx, o2_cy, o2_pc, o16_pc); end
        total++; if ({o2_found, o2_valid, o2_busy, o16_found, o16_valid, o16_busy} !== 6'b0) begin bad++; $display("FAIL rst_flags got=%b exp=000000", {o2_found, o2_valid, o2_busy, o16_found, o16_valid, o16_busy}); end
`ifdef BLOB_BBOX_EN
        total++; if ({o2_xmin, o2_xmax, o2_ymin, o2_ymax} !== 40'd0) begin bad++; $display("FAIL rst_bbox got=%0d,%0d,%0d,%0d exp=0", o2_xmin, o2_xmax, o2_ymin, o2_ymax); end
`endif
        get_done = 1'b1;
        step();
        get_done = 1'b0;
        v2 = 0;
        for (int n = 0; n < 10; n++) begin
            if (o2_valid || o16_valid || o2_busy) v2++;
            step();
        end
        total++; if (v2 != 0) begin bad++; $display("FAIL rst_idle got=%0d active cycles exp=0", v2); end
        $display("test_rst_mid_div: outputs cleared");
    endtask

    initial begin
        test_reset();
        test_main();
        test_same_cycle();
        test_too_few();
        test_light_only();
        test_ignore_outside();
        test_abort();
        test_rst_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
